argmax_cell: RTL and testbench

//   Streaming argmax reducer for the classifier output stage.
//   - Consumes (index, value) pairs, one per enabled cycle.
//   - After every CELL_AMOUNT accepted pairs, emits the index of the largest value.
//   - The result is flagged valid for exactly one cycle.
//   - Sits after the final layer's score cells and yields the predicted class.

---
 rtl/argmax_cell.sv | 83 ++++++++
 tb/tb_argmax_cell.sv | 138 +++++++++++++
 2 files changed

// File: rtl/argmax_cell.sv
`default_nettype none
// ============================================================================
//  Module   : argmax_cell
//  Purpose  : Streaming argmax reducer. Accepts one (index, value) pair per
//             enabled cycle and, after every CELL_AMOUNT accepted pairs,
//             emits the index of the largest value as a one-cycle pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module argmax_cell #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned CELL_AMOUNT  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   input_index,
  input  logic [DATA_WIDTH-1:0]   input_value,
  input  logic                    input_enable,
  output logic [RESULT_WIDTH:0]   output_result
);

  // Counter is wide enough to hold CELL_AMOUNT itself, so it is never zero width.
  localparam int unsigned        c_CNT_W = $clog2(CELL_AMOUNT + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CELL_AMOUNT - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0]    count_q,      count_d;
  logic [DATA_WIDTH-1:0] best_value_q, best_value_d;
  logic [DATA_WIDTH-1:0] best_index_q, best_index_d;
  logic [RESULT_WIDTH:0] result_q,     result_d;

  logic                  w_first;
  logic                  w_last;
  logic                  w_take;

  // Next-state: fold the incoming pair into the running best and close the
  // frame on its last pair. The first pair of a frame is taken unconditionally;
  // later pairs only win on a strictly larger value, so ties keep the earliest.
  always_comb begin
    count_d      = count_q;
    best_value_d = best_value_q;
    best_index_d = best_index_q;
    result_d     = '0;

    w_first = (count_q == '0);
    w_last  = (count_q == c_LAST);
    w_take  = w_first || (input_value > best_value_q);

    if (input_enable) begin
      if (w_take) begin
        best_value_d = input_value;
        best_index_d = input_index;
      end
      if (w_last) begin
        // With CELL_AMOUNT==1 the first pair is also the last one.
        result_d = {1'b1, RESULT_WIDTH'(w_take ? input_index : best_index_q)};
        count_d  = '0;
      end else begin
        count_d  = count_q + c_ONE;
      end
    end
  end

  // State and registered result; reset discards any partial frame and wins
  // over a pair presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      best_value_q <= '0;
      best_index_q <= '0;
      result_q     <= '0;
    end else begin
      count_q      <= count_d;
      best_value_q <= best_value_d;
      best_index_q <= best_index_d;
      result_q     <= result_d;
    end
  end

  assign output_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_argmax_cell.sv
`default_nettype none
// ============================================================================
//  Module   : tb_argmax_cell
//  Purpose  : Self-checking bench for argmax_cell: directed scenarios plus
//             randomized traffic against a queue-based frame model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_cell;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned RESULT_WIDTH = 16;
  localparam int unsigned CELL_AMOUNT  = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [DATA_WIDTH-1:0] input_index = '0;
  logic [DATA_WIDTH-1:0] input_value = '0;
  logic                  input_enable = 1'b0;
  logic [RESULT_WIDTH:0] output_result;

  int n_checks = 0;
  int n_errors = 0;

  // Pairs accepted so far in the currently open frame.
  logic [DATA_WIDTH-1:0] frame_idx[$];
  logic [DATA_WIDTH-1:0] frame_val[$];

  argmax_cell #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESULT_WIDTH(RESULT_WIDTH),
    .CELL_AMOUNT (CELL_AMOUNT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_index  (input_index),
    .input_value  (input_value),
    .input_enable (input_enable),
    .output_result(output_result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [RESULT_WIDTH:0] observed,
                          input logic [RESULT_WIDTH:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Apply one cycle of stimulus, predict the output from the frame model and
  // compare one time step after the rising edge.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [DATA_WIDTH-1:0] idx,
                      input logic [DATA_WIDTH-1:0] val);
    logic [RESULT_WIDTH:0] exp;
    int best;
    @(negedge clk);
    reset        = r;
    input_enable = en;
    input_index  = idx;
    input_value  = val;
    exp = '0;
    if (r) begin
      frame_idx.delete();
      frame_val.delete();
    end else if (en) begin
      frame_idx.push_back(idx);
      frame_val.push_back(val);
      if (frame_idx.size() == CELL_AMOUNT) begin
        best = 0;
        for (int i = 1; i < frame_val.size(); i++)
          if (frame_val[i] > frame_val[best]) best = i;
        exp = {1'b1, RESULT_WIDTH'(frame_idx[best])};
        frame_idx.delete();
        frame_val.delete();
      end
    end
    @(posedge clk);
    #1;
    check_eq(tag, output_result, exp);
  endtask

  initial begin
    // Reset and idle with wiggling inputs.
    step("reset0", 1'b1, 1'b0, 8'd0, 8'd0);
    step("reset1", 1'b1, 1'b1, 8'd7, 8'd9);
    step("idle0",  1'b0, 1'b0, 8'd1, 8'd0);
    step("idle1",  1'b0, 1'b0, 8'd0, 8'd1);

    // Larger value first.
    step("f1p0", 1'b0, 1'b1, 8'd0, 8'd2);
    step("f1p1", 1'b0, 1'b1, 8'd1, 8'd1);
    // Larger value second, then output drops.
    step("f2p0", 1'b0, 1'b1, 8'd0, 8'd3);
    step("f2p1", 1'b0, 1'b1, 8'd1, 8'd6);
    step("f2gap", 1'b0, 1'b0, 8'd0, 8'd0);
    // Gap inside a frame.
    step("f3p0", 1'b0, 1'b1, 8'd0, 8'd3);
    step("f3gap", 1'b0, 1'b0, 8'd1, 8'd6);
    step("f3p1", 1'b0, 1'b1, 8'd1, 8'd1);
    // Tie and extreme values, back to back.
    step("tie0", 1'b0, 1'b1, 8'd4, 8'd7);
    step("tie1", 1'b0, 1'b1, 8'd9, 8'd7);
    step("max0", 1'b0, 1'b1, 8'd2, 8'd255);
    step("max1", 1'b0, 1'b1, 8'd3, 8'd254);
    // Reset mid-frame discards the partial frame.
    step("mid0", 1'b0, 1'b1, 8'd8, 8'd200);
    step("midr", 1'b1, 1'b0, 8'd0, 8'd0);
    step("mid1", 1'b0, 1'b1, 8'd5, 8'd1);
    step("mid2", 1'b0, 1'b1, 8'd6, 8'd9);
    // Reset coinciding with an enabled pair drops that pair.
    step("rwp0", 1'b0, 1'b1, 8'd11, 8'd50);
    step("rwp1", 1'b1, 1'b1, 8'd12, 8'd60);
    step("rwp2", 1'b0, 1'b1, 8'd13, 8'd10);
    step("rwp3", 1'b0, 1'b1, 8'd14, 8'd20);

    // Randomized traffic: mostly enabled, occasional reset, narrow value
    // ranges mixed in to provoke ties.
    for (int n = 0; n < 400; n++) begin
      logic                  r, en;
      logic [DATA_WIDTH-1:0] idx, val;
      r   = ($urandom_range(0, 99) < 3);
      en  = ($urandom_range(0, 99) < 70);
      idx = DATA_WIDTH'($urandom);
      val = ($urandom_range(0, 1) == 1) ? DATA_WIDTH'($urandom_range(0, 3))
                                         : DATA_WIDTH'($urandom);
      step("rand", r, en, idx, val);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
